game_core: RTL and testbench



---
 rtl/game_core.sv | 209 ++++++++++++++++++++
 tb/tb_game_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_core.sv
// game_core: Whac-A-Mole game control core.
//   Owns the game FSM (IDLE/RUN/PAUSE/WIN/LOSE), score, countdown, level and
//   per-mole lifetimes. All outputs are registered.
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   start_click  one-cycle pulse, any left click
//   pause_click  one-cycle pulse, click on pause button
//   hit_mole     one-cycle pulses, click inside mole i
//   rand_idx     random mole index, sampled at each spawn attempt
//   state        0 IDLE, 1 RUN, 2 PAUSE, 3 WIN, 4 LOSE
//   mole_up      bit i = mole i visible
//   score        hits this game (saturating)
//   time_left    seconds remaining
//   level        current level, 1..MAX_LEVEL
//   hit_pulse    one cycle per accepted hit
//   miss_pulse   one cycle when any mole expires un-hit
//   is_win       high in WIN
module game_core #(
  parameter int N_MOLES      = 12,
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int WIN_SCORE    = 30,
  parameter int LEVEL_STEP   = 5,
  parameter int MAX_LEVEL    = 9,
  parameter int SPAWN_BASE   = 50_000_000,
  parameter int SPAWN_DEC    = 4_000_000,
  parameter int UP_BASE      = 80_000_000,
  parameter int UP_DEC       = 6_000_000,
  parameter int IDX_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_click,
  input  logic               pause_click,
  input  logic [N_MOLES-1:0] hit_mole,
  input  logic [IDX_W-1:0]   rand_idx,
  output logic [2:0]         state,
  output logic [N_MOLES-1:0] mole_up,
  output logic [15:0]        score,
  output logic [15:0]        time_left,
  output logic [3:0]         level,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               is_win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [31:0] STEP_LAST = 32'(LEVEL_STEP - 1);

  state_t             r_state;
  logic [N_MOLES-1:0] r_mole_up;
  logic [15:0]        r_score;
  logic [15:0]        r_time_left;
  logic [3:0]         r_level;
  logic               r_hit_pulse;
  logic               r_miss_pulse;
  logic               r_is_win;
  logic [31:0]        r_presc;
  logic [31:0]        r_spawn_cnt;
  logic [31:0]        r_step_cnt;   // hits since last level boundary
  logic [31:0]        r_life [N_MOLES];

  logic [31:0]        w_lvl_m1;
  logic [31:0]        w_spawn_last;
  logic [31:0]        w_up_time;
  logic               w_spawn_try;
  logic               w_tick;
  logic [N_MOLES-1:0] w_valid;
  logic [N_MOLES-1:0] w_hit_oh;
  logic               w_hit_any;
  logic               w_score_inc;
  logic [15:0]        w_score_nx;
  logic               w_win;
  logic [N_MOLES-1:0] w_exp;
  logic [N_MOLES-1:0] w_spawn_oh;

  assign w_lvl_m1     = 32'(r_level) - 32'd1;
  assign w_spawn_last = 32'(SPAWN_BASE) - w_lvl_m1 * 32'(SPAWN_DEC) - 32'd1;
  assign w_up_time    = 32'(UP_BASE) - w_lvl_m1 * 32'(UP_DEC);
  // >= rather than == so a level-up that shortens the period mid-count
  // cannot leave the counter stranded above the new terminal value.
  assign w_spawn_try  = r_spawn_cnt >= w_spawn_last;
  assign w_tick       = r_presc == TICK_LAST;

  // Lowest-index valid hit only: isolate the least significant set bit.
  assign w_valid     = hit_mole & r_mole_up;
  assign w_hit_oh    = w_valid & (~w_valid + N_MOLES'(1));
  assign w_hit_any   = |w_hit_oh;
  assign w_score_inc = w_hit_any && (r_score != 16'hFFFF);
  assign w_score_nx  = r_score + {15'd0, w_score_inc};
  assign w_win       = w_score_inc && (32'(w_score_nx) >= 32'(WIN_SCORE));

  // A hit on a mole masks both its expiry and any spawn onto it this cycle.
  // Out-of-range rand_idx matches no lane, so that attempt simply lapses.
  always_comb begin
    w_exp      = '0;
    w_spawn_oh = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      w_exp[i]      = r_mole_up[i] && (r_life[i] == 32'd1) && !w_hit_oh[i];
      w_spawn_oh[i] = w_spawn_try && (32'(rand_idx) == 32'(i)) &&
                      !r_mole_up[i] && !w_hit_oh[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mole_up    <= '0;
      r_score      <= '0;
      r_time_left  <= 16'(GAME_SECONDS);
      r_level      <= 4'd1;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_is_win     <= 1'b0;
      r_presc      <= '0;
      r_spawn_cnt  <= '0;
      r_step_cnt   <= '0;
      for (int i = 0; i < N_MOLES; i++) r_life[i] <= '0;
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc     <= '0;
          r_spawn_cnt <= '0;
          if (start_click) r_state <= S_RUN;
        end
        S_RUN: begin
          if (pause_click) begin
            // Pause swallows everything else in this cycle.
            r_state <= S_PAUSE;
          end else begin
            if (w_tick) begin
              r_presc     <= '0;
              r_time_left <= r_time_left - 16'd1;
            end else begin
              r_presc <= r_presc + 32'd1;
            end
            r_spawn_cnt <= w_spawn_try ? '0 : r_spawn_cnt + 32'd1;

            for (int i = 0; i < N_MOLES; i++) begin
              if (w_spawn_oh[i])     r_life[i] <= w_up_time;
              else if (w_hit_oh[i])  r_life[i] <= '0;
              else if (r_mole_up[i]) r_life[i] <= r_life[i] - 32'd1;
            end
            r_mole_up    <= (r_mole_up & ~w_hit_oh & ~w_exp) | w_spawn_oh;
            r_hit_pulse  <= w_hit_any;
            r_miss_pulse <= |w_exp;

            if (w_score_inc) begin
              r_score <= w_score_nx;
              if (r_step_cnt == STEP_LAST) begin
                r_step_cnt <= '0;
                if (r_level < 4'(MAX_LEVEL)) r_level <= r_level + 4'd1;
              end else begin
                r_step_cnt <= r_step_cnt + 32'd1;
              end
            end

            // Win beats a simultaneous final-second timeout.
            if (w_win) begin
              r_state   <= S_WIN;
              r_is_win  <= 1'b1;
              r_mole_up <= '0;
            end else if (w_tick && r_time_left == 16'd1) begin
              r_state   <= S_LOSE;
              r_mole_up <= '0;
            end
          end
        end
        S_PAUSE: begin
          if (pause_click) r_state <= S_RUN;
        end
        S_WIN, S_LOSE: begin
          if (start_click) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_time_left <= 16'(GAME_SECONDS);
            r_level     <= 4'd1;
            r_mole_up   <= '0;
            r_is_win    <= 1'b0;
            r_step_cnt  <= '0;
            for (int i = 0; i < N_MOLES; i++) r_life[i] <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state      = r_state;
  assign mole_up    = r_mole_up;
  assign score      = r_score;
  assign time_left  = r_time_left;
  assign level      = r_level;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign is_win     = r_is_win;

endmodule

// File: tb/tb_game_core.sv
// Directed bench for game_core with small timing parameters.
module tb_game_core;

  localparam int N = 12;

  logic          clk;
  logic          reset;
  logic          start_click;
  logic          pause_click;
  logic [N-1:0]  hit_mole;
  logic [3:0]    rand_idx;
  logic [2:0]    state;
  logic [N-1:0]  mole_up;
  logic [15:0]   score;
  logic [15:0]   time_left;
  logic [3:0]    level;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          is_win;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  game_core #(
    .N_MOLES(N), .TICK_CYCLES(10), .GAME_SECONDS(3), .WIN_SCORE(4),
    .LEVEL_STEP(2), .MAX_LEVEL(9), .SPAWN_BASE(8), .SPAWN_DEC(2),
    .UP_BASE(20), .UP_DEC(4), .IDX_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start_click(start_click),
    .pause_click(pause_click), .hit_mole(hit_mole), .rand_idx(rand_idx),
    .state(state), .mole_up(mole_up), .score(score), .time_left(time_left),
    .level(level), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .is_win(is_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start_click from IDLE; afterwards cyc counts RUN edges from entry.
  task automatic start_game();
    start_click = 1'b1;
    tick();
    start_click = 1'b0;
    cyc = 0;
  endtask

  // start_click from WIN/LOSE must restore the fresh-game values.
  task automatic restart(input string tag);
    start_click = 1'b1;
    tick();
    start_click = 1'b0;
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_time"},  32'(time_left), 32'd3);
    chk({tag, "_level"}, 32'(level), 32'd1);
    chk({tag, "_win"},   32'(is_win), 32'd0);
    chk({tag, "_moles"}, 32'(mole_up), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start_click = 1'b0; pause_click = 1'b0;
    hit_mole = '0; rand_idx = 4'd13;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_moles", 32'(mole_up), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_time",  32'(time_left), 32'd3);
    chk("rst_level", 32'(level), 32'd1);
    chk("rst_hitp",  32'(hit_pulse), 32'd0);
    chk("rst_missp", 32'(miss_pulse), 32'd0);
    chk("rst_win",   32'(is_win), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    // ---- Game A: timeout, rand_idx out of range so nothing spawns
    start_game();
    chk("A_run", 32'(state), 32'd1);
    go_to(9);  chk("A_t9",  32'(time_left), 32'd3);
    go_to(10); chk("A_t10", 32'(time_left), 32'd2);
    go_to(20); chk("A_t20", 32'(time_left), 32'd1);
    chk("A_nospawn", 32'(mole_up), 32'd0);
    go_to(29); chk("A_run29", 32'(state), 32'd1);
    go_to(30);
    chk("A_t30",   32'(time_left), 32'd0);
    chk("A_lose",  32'(state), 32'd4);
    chk("A_win",   32'(is_win), 32'd0);
    chk("A_moles", 32'(mole_up), 32'd0);
    tick();
    chk("A_hold", 32'(state), 32'd4);
    restart("A_rs");

    // ---- Game B: spawn at cycle 8, expiry 20 cycles later
    rand_idx = 4'd5;
    start_game();
    go_to(7); chk("B_pre",   32'(mole_up), 32'd0);
    go_to(8); chk("B_spawn", 32'(mole_up), 32'h020);
    go_to(27); chk("B_up27", 32'(mole_up), 32'h020);
    go_to(28);
    chk("B_exp",   32'(mole_up), 32'd0);
    chk("B_missp", 32'(miss_pulse), 32'd1);
    go_to(29); chk("B_missp_off", 32'(miss_pulse), 32'd0);
    go_to(30); chk("B_lose", 32'(state), 32'd4);
    restart("B_rs");

    // ---- Game C: hits, levels, faster spawn, win on final tick
    rand_idx = 4'd5;
    start_game();
    go_to(8); chk("C_up8", 32'(mole_up), 32'h020);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 9
    chk("C_h1_score", 32'(score), 32'd1);
    chk("C_h1_pulse", 32'(hit_pulse), 32'd1);
    chk("C_h1_moles", 32'(mole_up), 32'd0);
    chk("C_h1_level", 32'(level), 32'd1);
    go_to(10); chk("C_h1_pulse_off", 32'(hit_pulse), 32'd0);
    go_to(11);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 12, mole down
    chk("C_down_score", 32'(score), 32'd1);
    chk("C_down_pulse", 32'(hit_pulse), 32'd0);
    go_to(16); chk("C_up16", 32'(mole_up), 32'h020);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 17
    chk("C_h2_score", 32'(score), 32'd2);
    chk("C_h2_level", 32'(level), 32'd2);
    go_to(21); chk("C_lvl2_pre", 32'(mole_up), 32'd0);
    go_to(22); chk("C_lvl2_spawn", 32'(mole_up), 32'h020);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 23
    chk("C_h3_score", 32'(score), 32'd3);
    chk("C_h3_level", 32'(level), 32'd2);
    go_to(28); chk("C_up28", 32'(mole_up), 32'h020);
    go_to(29);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 30, final tick
    chk("C_win_state", 32'(state), 32'd3);
    chk("C_win_flag",  32'(is_win), 32'd1);
    chk("C_win_score", 32'(score), 32'd4);
    chk("C_win_moles", 32'(mole_up), 32'd0);
    chk("C_win_level", 32'(level), 32'd3);
    tick(); tick(); tick();
    chk("C_win_hold", 32'(state), 32'd3);
    chk("C_win_hold_score", 32'(score), 32'd4);
    restart("C_rs");

    // ---- Game D: lowest-index hit, hit on the expiring cycle
    rand_idx = 4'd5;
    start_game();
    go_to(8); rand_idx = 4'd2;
    go_to(16); chk("D_two_up", 32'(mole_up), 32'h024);
    rand_idx = 4'd13;
    hit_mole = 12'h024; tick(); hit_mole = '0;           // edge 17
    chk("D_low_moles", 32'(mole_up), 32'h020);
    chk("D_low_score", 32'(score), 32'd1);
    go_to(27); chk("D_up27", 32'(mole_up), 32'h020);
    hit_mole = 12'h020; tick(); hit_mole = '0;           // edge 28, last life cycle
    chk("D_sim_score", 32'(score), 32'd2);
    chk("D_sim_hitp",  32'(hit_pulse), 32'd1);
    chk("D_sim_missp", 32'(miss_pulse), 32'd0);
    chk("D_sim_moles", 32'(mole_up), 32'd0);
    chk("D_sim_level", 32'(level), 32'd2);
    go_to(30); chk("D_lose", 32'(state), 32'd4);
    restart("D_rs");

    // ---- Game E: pause freeze/resume, pause beats hit, mid-game reset
    rand_idx = 4'd5;
    start_game();
    go_to(4);
    pause_click = 1'b1; tick(); pause_click = 1'b0;      // edge 5 discarded
    chk("E_paused", 32'(state), 32'd2);
    repeat (50) tick();
    chk("E_frz_state", 32'(state), 32'd2);
    chk("E_frz_time",  32'(time_left), 32'd3);
    chk("E_frz_moles", 32'(mole_up), 32'd0);
    pause_click = 1'b1; tick(); pause_click = 1'b0;      // resume edge R
    chk("E_resumed", 32'(state), 32'd1);
    cyc = 0;
    // presc and spawn count both resume at 4: spawn at R+4, tick at R+6.
    go_to(3); chk("E_r3_moles", 32'(mole_up), 32'd0);
    go_to(4); chk("E_r4_moles", 32'(mole_up), 32'h020);
    go_to(5); chk("E_r5_time",  32'(time_left), 32'd3);
    go_to(6); chk("E_r6_time",  32'(time_left), 32'd2);
    pause_click = 1'b1; hit_mole = 12'h020; tick();
    pause_click = 1'b0; hit_mole = '0;
    chk("E_ph_state", 32'(state), 32'd2);
    chk("E_ph_score", 32'(score), 32'd0);
    chk("E_ph_moles", 32'(mole_up), 32'h020);
    chk("E_ph_pulse", 32'(hit_pulse), 32'd0);
    hit_mole = 12'h020; tick(); hit_mole = '0;
    chk("E_pz_score", 32'(score), 32'd0);
    chk("E_pz_moles", 32'(mole_up), 32'h020);
    pause_click = 1'b1; tick(); pause_click = 1'b0;
    chk("E_run2", 32'(state), 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("E_rst_state", 32'(state), 32'd0);
    chk("E_rst_moles", 32'(mole_up), 32'd0);
    chk("E_rst_time",  32'(time_left), 32'd3);
    chk("E_rst_level", 32'(level), 32'd1);
    chk("E_rst_score", 32'(score), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
